mem_responder_512x32: RTL and testbench
=======================================

Name: mem_responder_512x32

Overview:
Memory-side responder for the control unit's memory strobes (Mem_Read, Mem_Write, Mem_enable512x32). It owns the 512x32 word store and accepts one request at a time. It returns read data after a parameterised number of wait states and signals completion with a one-cycle ready pulse. It sits between MAR/MDR and the MDR memory-data input.

Parameters:
DATA_WIDTH, 32, word width and width of the address input.
ADDR_WIDTH, 9, index width; depth = 2**ADDR_WIDTH = 512.
READ_WAIT, 1, read wait states, legal range 0..7.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
Mem_enable512x32  in  1  request qualifier.
Mem_Read  in  1  read strobe, sampled only with enable.
Mem_Write  in  1  write strobe, sampled only with enable.
addr  in  DATA_WIDTH  byte-free word address from MAR.
wdata  in  DATA_WIDTH  write data from MDR.
rdata  out  DATA_WIDTH  read data to MDR mux; registered.
mem_ready  out  1  one-cycle completion pulse, for reads and writes.
mem_busy  out  1  high while a request is in flight.
err_clr  in  1  synchronous clear of the sticky error flags.
addr_fault  out  1  sticky: out-of-range address seen.
req_fault  out  1  sticky: dropped request, or Read and Write both high.

Behaviour:
- Reset (reset=0, async): state=IDLE; rdata=0, mem_ready=0, mem_busy=0, addr_fault=0, req_fault=0; wait counter=0. Array contents are not reset.
- Request sampled at a rising edge in IDLE when Mem_enable512x32=1 and exactly one of Mem_Read/Mem_Write=1. Call the cycle before that edge C.
- States: IDLE, WAIT, RESP.
- Write, in-range:
  - Array[addr[ADDR_WIDTH-1:0]] <= wdata at the accept edge.
  - Next state RESP; mem_ready=1 in cycle C+1; then IDLE.
  - rdata unchanged.
- Read, in-range:
  - addr index is latched at the accept edge.
  - If READ_WAIT>0: go to WAIT with counter=READ_WAIT-1; count down to 0 (READ_WAIT cycles); then RESP.
  - If READ_WAIT=0: go directly to RESP.
  - On the edge entering RESP, rdata <= array[latched index], so RESP is cycle C+READ_WAIT+1.
  - mem_ready=1 for exactly that RESP cycle; then IDLE.
  - rdata holds its value until the next read completes.
- mem_busy=1 in WAIT and RESP, 0 in IDLE. Not asserted during the accept cycle C itself.
- Out-of-range: addr[DATA_WIDTH-1:ADDR_WIDTH] != 0.
  - Request still proceeds with the same timing and mem_ready pulse.
  - Write is suppressed.
  - Read loads rdata=0.
  - addr_fault set at the accept edge.
- Both strobes high with enable in IDLE: no access, no state change, no mem_ready; req_fault set.
- Strobes with enable low: ignored entirely.
- Request while mem_busy=1 (WAIT or RESP): dropped, no side effects on array or rdata; req_fault set. A request presented in the RESP cycle is also dropped; back-to-back requests need one idle cycle.
- err_clr=1 clears both sticky flags at the edge. If a new fault occurs at the same edge, set wins.
- Read-after-write to the same address returns the new data, because the write commits at its accept edge.
- Reset asserted mid-read aborts the read: no mem_ready, rdata=0. An accepted write is already committed.

Test Plan:
- READ_WAIT=1. Reset, write 0xDEADBEEF to addr 5 -> mem_ready=1 exactly in cycle C+1, mem_busy=1 in C+1 only. Then read addr 5 -> rdata=0xDEADBEEF with mem_ready in cycle C+2, mem_busy high in C+1..C+2.
- READ_WAIT=0 and READ_WAIT=7. Write 0x12345678 to addr 511, then read addr 511 -> mem_ready at C+1 and C+8 respectively; rdata=0x12345678; rdata holds after the pulse.
- Write 0xAAAA5555 to addr 0x200 (out-of-range) -> mem_ready at C+1, addr_fault=1, addr 0 still holds its prior value. Then read 0x200 -> rdata=0. Then err_clr -> addr_fault=0.
- Read addr 3 then re-issue the strobe during WAIT -> second request dropped, only one mem_ready pulse, req_fault=1. Separately, Mem_Read=Mem_Write=1 with enable in IDLE -> req_fault=1, no mem_ready, array unchanged.
- READ_WAIT=3. Start a read of addr 7 (holding 0x55), pull reset low at C+2 -> rdata=0, mem_busy=0, mem_ready never pulses. After release, read addr 7 -> 0x55 (array retained).
- Strobes pulsed with Mem_enable512x32=0 -> no mem_ready, no flags, array and rdata unchanged.

Source files
------------

// File: rtl/mem_responder_512x32.sv
// Memory-side responder: one request at a time against a 512x32 word store, with a
// programmable number of read wait states, a one-cycle ready pulse and sticky fault flags.
module mem_responder_512x32 #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int READ_WAIT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Mem_enable512x32,
    input  logic                  Mem_Read,
    input  logic                  Mem_Write,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_ready,
    output logic                  mem_busy,
    input  logic                  err_clr,
    output logic                  addr_fault,
    output logic                  req_fault
);
    localparam int         DEPTH     = 2 ** ADDR_WIDTH;
    localparam bit         HAS_WAIT  = (READ_WAIT > 0);
    localparam logic [2:0] WAIT_INIT = HAS_WAIT ? 3'(READ_WAIT - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    oor_q, oor_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    addr_fault_q, addr_fault_d;
    logic                    req_fault_q, req_fault_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    in_range_s;
    logic                    accept_s;
    logic                    wr_en_s;
    logic                    rd_load_s;
    logic [ADDR_WIDTH-1:0]   rd_idx_s;
    logic                    rd_oor_s;

    // Request decode, next-state logic and next values of all registered outputs.
    always_comb begin
        in_range_s = (addr[DATA_WIDTH-1:ADDR_WIDTH] == {(DATA_WIDTH-ADDR_WIDTH){1'b0}});
        accept_s   = (state_q == IDLE) & Mem_enable512x32 & (Mem_Read ^ Mem_Write);
        wr_en_s    = accept_s & Mem_Write & in_range_s & reset;

        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        oor_d     = oor_q;
        rd_load_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    idx_d = addr[ADDR_WIDTH-1:0];
                    oor_d = ~in_range_s;
                    if (Mem_Read && HAS_WAIT) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d   = RESP;
                        rd_load_s = Mem_Read;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    state_d   = RESP;
                    rd_load_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A zero-wait read loads rdata on its accept edge, before idx_q holds the index.
        if (state_q == IDLE) begin
            rd_idx_s = addr[ADDR_WIDTH-1:0];
            rd_oor_s = ~in_range_s;
        end else begin
            rd_idx_s = idx_q;
            rd_oor_s = oor_q;
        end

        if (rd_load_s) begin
            rdata_d = rd_oor_s ? {DATA_WIDTH{1'b0}} : mem_q[rd_idx_s];
        end else begin
            rdata_d = rdata_q;
        end

        ready_d      = (state_d == RESP);
        busy_d       = (state_d != IDLE);
        addr_fault_d = (addr_fault_q & ~err_clr) | (accept_s & ~in_range_s);
        req_fault_d  = (req_fault_q & ~err_clr)
                     | ((state_q != IDLE) & Mem_enable512x32 & (Mem_Read | Mem_Write))
                     | ((state_q == IDLE) & Mem_enable512x32 & Mem_Read & Mem_Write);
    end

    // Word store; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[addr[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            idx_q        <= {ADDR_WIDTH{1'b0}};
            oor_q        <= 1'b0;
            rdata_q      <= {DATA_WIDTH{1'b0}};
            ready_q      <= 1'b0;
            busy_q       <= 1'b0;
            addr_fault_q <= 1'b0;
            req_fault_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            oor_q        <= oor_d;
            rdata_q      <= rdata_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            addr_fault_q <= addr_fault_d;
            req_fault_q  <= req_fault_d;
        end
    end

    assign rdata      = rdata_q;
    assign mem_ready  = ready_q;
    assign mem_busy   = busy_q;
    assign addr_fault = addr_fault_q;
    assign req_fault  = req_fault_q;

endmodule

// File: tb/tb_mem_responder_512x32.sv
// Scoreboard bench: four responders (READ_WAIT 0/1/3/7) share one stimulus stream;
// each expected completion is queued at issue time and popped when mem_ready pulses.
module tb_mem_responder_512x32;
    localparam int N = 4;

    function automatic int rw_of(input int g);
        case (g)
            0:       return 0;
            1:       return 1;
            2:       return 3;
            default: return 7;
        endcase
    endfunction

    typedef struct {
        int          start;
        int          due;
        logic [31:0] data;
    } exp_t;

    logic         clk     = 1'b0;
    logic [N-1:0] rst_n_s = '0;
    logic         en_s    = 1'b0;
    logic         rd_s    = 1'b0;
    logic         wr_s    = 1'b0;
    logic         clr_s   = 1'b0;
    logic [31:0]  addr_s  = 32'd0;
    logic [31:0]  wdata_s = 32'd0;

    wire  [31:0]  rdata_s [N];
    wire  [N-1:0] ready_s;
    wire  [N-1:0] busy_s;
    wire  [N-1:0] af_s;
    wire  [N-1:0] rf_s;

    exp_t         sb_q [N][$];
    logic [31:0]  mdl [512];
    logic [31:0]  last_rd [N];
    logic [N-1:0] af_exp;
    logic [N-1:0] rf_exp;
    int           cyc   = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_responder_512x32 #(
            .DATA_WIDTH(32),
            .ADDR_WIDTH(9),
            .READ_WAIT (rw_of(g))
        ) u_dut (
            .clk             (clk),
            .reset           (rst_n_s[g]),
            .Mem_enable512x32(en_s),
            .Mem_Read        (rd_s),
            .Mem_Write       (wr_s),
            .addr            (addr_s),
            .wdata           (wdata_s),
            .rdata           (rdata_s[g]),
            .mem_ready       (ready_s[g]),
            .mem_busy        (busy_s[g]),
            .err_clr         (clr_s),
            .addr_fault      (af_s[g]),
            .req_fault       (rf_s[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int d = 0; d < N; d++) s += sb_q[d].size();
        return s;
    endfunction

    // Per-cycle observation of every instance against the scoreboard.
    task automatic mon();
        for (int d = 0; d < N; d++) begin
            exp_t e;
            bit   exp_busy;
            exp_busy = (sb_q[d].size() > 0) && (cyc > sb_q[d][0].start) && (cyc <= sb_q[d][0].due);
            chk($sformatf("busy[%0d]", d), {31'd0, busy_s[d]}, {31'd0, exp_busy});
            chk($sformatf("addr_fault[%0d]", d), {31'd0, af_s[d]}, {31'd0, af_exp[d]});
            chk($sformatf("req_fault[%0d]", d), {31'd0, rf_s[d]}, {31'd0, rf_exp[d]});
            if (ready_s[d]) begin
                if (sb_q[d].size() == 0) begin
                    chk($sformatf("spurious_ready[%0d]", d), 32'd1, 32'd0);
                end else begin
                    e = sb_q[d].pop_front();
                    chk($sformatf("ready_cycle[%0d]", d), 32'(cyc), 32'(e.due));
                    chk($sformatf("rdata[%0d]", d), rdata_s[d], e.data);
                    last_rd[d] = e.data;
                end
            end else begin
                if (sb_q[d].size() > 0 && cyc > sb_q[d][0].due) begin
                    e = sb_q[d].pop_front();
                    chk($sformatf("missed_ready[%0d]", d), 32'(cyc), 32'(e.due));
                end
                chk($sformatf("rdata_hold[%0d]", d), rdata_s[d], last_rd[d]);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Drive one request cycle; idle=0 means the responders are known to be busy.
    task automatic issue(input logic en, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d, input bit idle);
        int c;
        bit oor;
        c       = cyc;
        oor     = (a[31:9] != 23'd0);
        en_s    = en;
        rd_s    = rd;
        wr_s    = wr;
        addr_s  = a;
        wdata_s = d;
        if (idle && en && (rd ^ wr)) begin
            for (int k = 0; k < N; k++) begin
                exp_t e;
                e.start = c;
                if (rd) begin
                    e.due  = c + rw_of(k) + 1;
                    e.data = oor ? 32'd0 : mdl[a[8:0]];
                end else begin
                    e.due  = c + 1;
                    e.data = last_rd[k];
                end
                sb_q[k].push_back(e);
            end
        end
        step();
        en_s = 1'b0;
        rd_s = 1'b0;
        wr_s = 1'b0;
        if (en && rd && wr) rf_exp = '1;
        else if (en && (rd || wr) && !idle) rf_exp = '1;
        else if (en && idle && (rd ^ wr) && oor) af_exp = '1;
        if (en && idle && wr && !rd && !oor) mdl[a[8:0]] = d;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (n < 30 && pending() > 0) begin
            step();
            n++;
        end
        chk("wait_idle_pending", 32'(pending()), 32'd0);
        step();
    endtask

    task automatic clear_err();
        clr_s = 1'b1;
        step();
        clr_s  = 1'b0;
        af_exp = '0;
        rf_exp = '0;
    endtask

    initial begin
        af_exp = '0;
        rf_exp = '0;
        for (int d = 0; d < N; d++) last_rd[d] = 32'd0;
        repeat (3) step();
        rst_n_s = '1;
        step();

        // Basic write then read.
        issue(1'b1, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b1);
        wait_idle();
        issue(1'b1, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
        wait_idle();

        // Top in-range address; rdata must hold after the pulse.
        issue(1'b1, 1'b0, 1'b1, 32'd511, 32'h12345678, 1'b1);
        wait_idle();
        issue(1'b1, 1'b1, 1'b0, 32'd511, 32'd0, 1'b1);
        wait_idle();
        repeat (2) step();

        // Out-of-range write/read, then clear.
        issue(1'b1, 1'b0, 1'b1, 32'd0, 32'h11110000, 1'b1);
        wait_idle();
        issue(1'b1, 1'b0, 1'b1, 32'h200, 32'hAAAA5555, 1'b1);
        wait_idle();
        issue(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b1);
        wait_idle();
        issue(1'b1, 1'b1, 1'b0, 32'h200, 32'd0, 1'b1);
        wait_idle();
        clear_err();
        step();

        // Request while busy is dropped.
        issue(1'b1, 1'b0, 1'b1, 32'd3, 32'h33333333, 1'b1);
        wait_idle();
        issue(1'b1, 1'b1, 1'b0, 32'd3, 32'd0, 1'b1);
        issue(1'b1, 1'b1, 1'b0, 32'd3, 32'd0, 1'b0);
        wait_idle();
        clear_err();

        // Both strobes: fault only, no access.
        issue(1'b1, 1'b1, 1'b1, 32'd3, 32'hBADBAD00, 1'b1);
        repeat (2) step();
        issue(1'b1, 1'b1, 1'b0, 32'd3, 32'd0, 1'b1);
        wait_idle();
        clear_err();

        // Strobes with enable low are ignored.
        issue(1'b0, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
        issue(1'b0, 1'b0, 1'b1, 32'd5, 32'h0BAD0BAD, 1'b1);
        repeat (2) step();
        issue(1'b1, 1'b1, 1'b0, 32'd5, 32'd0, 1'b1);
        wait_idle();

        // Reset mid-read on the READ_WAIT=3 instance.
        issue(1'b1, 1'b0, 1'b1, 32'd7, 32'h00000055, 1'b1);
        wait_idle();
        issue(1'b1, 1'b1, 1'b0, 32'd7, 32'd0, 1'b1);
        step();
        rst_n_s[2] = 1'b0;
        sb_q[2].delete();
        last_rd[2] = 32'd0;
        af_exp[2]  = 1'b0;
        rf_exp[2]  = 1'b0;
        step();
        chk("abort_rdata", rdata_s[2], 32'd0);
        chk("abort_busy", {31'd0, busy_s[2]}, 32'd0);
        step();
        rst_n_s[2] = 1'b1;
        wait_idle();
        issue(1'b1, 1'b1, 1'b0, 32'd7, 32'd0, 1'b1);
        wait_idle();
        repeat (2) step();

        chk("sb_empty", 32'(pending()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
